// File: rtl/ram_dump_tx_pkg.sv
// Shared definitions for the RAM dump transmitter: FSM state encodings and
// UART 8N1 frame constants.
package ram_dump_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_CSUM = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  localparam logic       UART_START     = 1'b0;
  localparam logic       UART_STOP      = 1'b1;
  localparam int         FRAME_BITS     = 10;
  localparam logic [2:0] BYTES_PER_WORD = 3'd4;

endpackage

// File: rtl/ram_dump_tx_uart_tx_byte.sv
// uart_tx_byte: one 8N1 frame per accepted send. ready also rises in the last
// cycle of a stop bit so a back-to-back byte starts with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  import ram_dump_tx_pkg::*;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic              active;
  logic [8:0]        frame;
  logic              bit_end;
  logic              frame_end;
  logic              load;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = active && bit_end && (bit_cnt == BIT_LAST);
  assign ready     = !active || frame_end;
  assign load      = send && ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= UART_STOP;
    end else if (load) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= UART_START;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active <= 1'b0;
          tx     <= UART_STOP;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= frame[0];
        end
      end else begin
        baud_cnt <= baud_cnt + BAUD_W'(1);
      end
    end
  end

  // Remaining bits after the start bit: data LSB first, then stop.
  always_ff @(posedge clk) begin
    if (load) begin
      frame <= {UART_STOP, data};
    end else if (active && bit_end) begin
      frame <= {UART_STOP, frame[8:1]};
    end
  end

endmodule

// File: rtl/ram_dump_tx.sv
// ram_dump_tx: reads a word window from the debug RAM port and streams it
// little-endian over UART 8N1. Optional trailing checksum byte: DUMP_CHECKSUM_EN.
module ram_dump_tx #(
  parameter int ADDR_W       = 10,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_b0,
  input  logic [7:0]        ram_b1,
  input  logic [7:0]        ram_b2,
  input  logic [7:0]        ram_b3,
  output logic              busy,
  output logic              done,
  output logic              tx
);
  import ram_dump_tx_pkg::*;

  state_t          state;
  logic [ADDR_W:0] words_left;
  logic [2:0]      byte_idx;
  logic [31:0]     word_sr;
  logic            uart_send;
  logic            uart_ready;
  logic [7:0]      uart_data;
  logic            byte_fire;
  logic            last_byte_done;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_sent;
`endif

  assign byte_fire      = (state == S_SEND) && (byte_idx != BYTES_PER_WORD) && uart_ready;
  assign last_byte_done = (state == S_SEND) && (byte_idx == BYTES_PER_WORD) && uart_ready;

  always_comb begin
    uart_send = byte_fire;
    uart_data = word_sr[7:0];
`ifdef DUMP_CHECKSUM_EN
    // The checksum goes out back-to-back with the final data byte.
    if (last_byte_done && (words_left == '0)) begin
      uart_send = 1'b1;
      uart_data = csum;
    end else if ((state == S_CSUM) && !csum_sent) begin
      uart_send = uart_ready;
      uart_data = csum;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      words_left <= '0;
      byte_idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_sent  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            ram_addr   <= base_addr;
            words_left <= word_cnt;
            if (word_cnt == '0) begin
`ifdef DUMP_CHECKSUM_EN
              csum_sent <= 1'b0;
              state     <= S_CSUM;
`else
              state     <= S_FIN;
`endif
            end else begin
              ram_re <= 1'b1;
              state  <= S_RD;
            end
          end
        end
        S_RD: begin
          ram_re     <= 1'b0;
          words_left <= words_left - (ADDR_W+1)'(1);
          state      <= S_WAIT;
        end
        S_WAIT: begin
          byte_idx <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (byte_fire) begin
            byte_idx <= byte_idx + 3'd1;
          end else if (last_byte_done) begin
            if (words_left != '0) begin
              ram_addr <= ram_addr + ADDR_W'(1);
              ram_re   <= 1'b1;
              state    <= S_RD;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              csum_sent <= 1'b1;
              state     <= S_CSUM;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (uart_ready) begin
            if (!csum_sent) begin
              csum_sent <= 1'b1;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
`endif
        S_FIN: begin
          // Entered with done already set after a stream; the empty dump arrives with it clear.
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WAIT) begin
      word_sr <= {ram_b3, ram_b2, ram_b1, ram_b0};
    end else if (byte_fire) begin
      word_sr <= {8'h00, word_sr[31:8]};
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      csum <= 8'h00;
    end else if (byte_fire) begin
      csum <= csum + word_sr[7:0];
    end
  end
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .send (uart_send),
    .data (uart_data),
    .ready(uart_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_ram_dump_tx.sv
// Directed bench for ram_dump_tx with a behavioural RAM and a UART receiver.
module tb_ram_dump_tx;

  localparam int AW  = 4;
  localparam int CPB = 4;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_b0, ram_b1, ram_b2, ram_b3;
  logic          busy, done, tx;

  logic [31:0] mem [16];
  logic [31:0] rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  // Monitor-owned state; tests only read it.
  logic [7:0] byte_q [$];
  logic [3:0] re_addr_q [$];
  int  done_cnt = 0;
  int  re_cnt = 0;
  int  fall_cnt = 0;
  int  frame_err = 0;
  bit  rx_active = 0;
  int  rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  logic prev_tx = 1'b1;
  bit  busy_gap;

  always #5 clk = ~clk;

  ram_dump_tx #(.ADDR_W(AW), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_b0(ram_b0), .ram_b1(ram_b1), .ram_b2(ram_b2), .ram_b3(ram_b3),
    .busy(busy), .done(done), .tx(tx)
  );

  always @(posedge clk) if (ram_re) rdata <= mem[ram_addr];
  assign ram_b0 = rdata[7:0];
  assign ram_b1 = rdata[15:8];
  assign ram_b2 = rdata[23:16];
  assign ram_b3 = rdata[31:24];

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 0;
      prev_tx = 1'b1;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (ram_re === 1'b1) begin
        re_cnt++;
        re_addr_q.push_back(ram_addr);
      end
      if (prev_tx === 1'b1 && tx === 1'b0) fall_cnt++;
      prev_tx = tx;
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if ((rx_cnt % CPB) == CPB/2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
          rx_byte[rx_cnt/CPB - 1] = tx;
        if (rx_cnt == 9*CPB + CPB/2) begin
          byte_q.push_back(rx_byte);
          if (tx !== 1'b1) frame_err++;
        end
        if (rx_cnt == 10*CPB - 1) rx_active = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b;
    word_cnt = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok = 0;
    busy_gap = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      if (busy !== 1'b1) busy_gap = 1;
    end
  endtask

  initial begin
    int cyc, b0, d0, r0, f0, e0;
    bit ok;
    logic [7:0] exp1 [4];
    logic [7:0] exp2 [8];
    logic [7:0] exp4 [4];
    logic [7:0] exp6 [4];
    exp1 = '{8'h44, 8'h33, 8'h22, 8'h11};
    exp2 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
    exp4 = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};
    exp6 = '{8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    repeat (3) tick();
    chk("rst_tx", {63'd0, tx}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ram_re", {63'd0, ram_re}, 64'd0);
    chk("rst_ram_addr", {60'd0, ram_addr}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: single word
    mem[0] = 32'h11223344;
    b0 = byte_q.size(); d0 = done_cnt; r0 = re_cnt; e0 = frame_err;
    pulse_start(4'd0, 5'd1);
    wait_done(400, cyc, ok);
    chk("t1_done_seen", {63'd0, ok}, 64'd1);
    chk("t1_latency_ok", {63'd0, (cyc >= 160 && cyc <= 170 + 40*CS)}, 64'd1);
    chk("t1_busy_held", {63'd0, busy_gap}, 64'd0);
    chk("t1_busy_low_at_done", {63'd0, busy}, 64'd0);
    tick();
    chk("t1_done_pulse", {63'd0, done}, 64'd0);
    chk("t1_nbytes", 64'(byte_q.size() - b0), 64'(4 + CS));
    for (int i = 0; i < 4; i++)
      if (b0 + i < byte_q.size()) chk($sformatf("t1_byte%0d", i), {56'd0, byte_q[b0+i]}, {56'd0, exp1[i]});
    chk("t1_reads", 64'(re_cnt - r0), 64'd1);
    chk("t1_read_addr", {60'd0, re_addr_q[r0]}, 64'd0);
    chk("t1_frame_ok", 64'(frame_err - e0), 64'd0);
    chk("t1_tx_idle", {63'd0, tx}, 64'd1);
`ifdef DUMP_CHECKSUM_EN
    if (byte_q.size() > 0) chk("t1_csum", {56'd0, byte_q[byte_q.size()-1]}, 64'hAA);
`endif
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // 2: address wrap 15 -> 0
    mem[15] = 32'hAABBCCDD;
    mem[0]  = 32'h01020304;
    b0 = byte_q.size(); d0 = done_cnt; r0 = re_cnt;
    pulse_start(4'd15, 5'd2);
    wait_done(800, cyc, ok);
    tick();
    chk("t2_done_seen", {63'd0, ok}, 64'd1);
    chk("t2_nbytes", 64'(byte_q.size() - b0), 64'(8 + CS));
    for (int i = 0; i < 8; i++)
      if (b0 + i < byte_q.size()) chk($sformatf("t2_byte%0d", i), {56'd0, byte_q[b0+i]}, {56'd0, exp2[i]});
    chk("t2_reads", 64'(re_cnt - r0), 64'd2);
    if (re_cnt - r0 >= 2) begin
      chk("t2_addr0", {60'd0, re_addr_q[r0]}, 64'd15);
      chk("t2_addr1", {60'd0, re_addr_q[r0+1]}, 64'd0);
    end
`ifdef DUMP_CHECKSUM_EN
    if (byte_q.size() > 0) chk("t2_csum", {56'd0, byte_q[byte_q.size()-1]}, 64'h18);
`endif
    chk("t2_done_count", 64'(done_cnt - d0), 64'd1);

    // 3: empty dump
    b0 = byte_q.size(); d0 = done_cnt; r0 = re_cnt; f0 = fall_cnt;
    pulse_start(4'd5, 5'd0);
`ifdef DUMP_CHECKSUM_EN
    wait_done(100, cyc, ok);
    tick();
    chk("t3_done_seen", {63'd0, ok}, 64'd1);
    chk("t3_nbytes", 64'(byte_q.size() - b0), 64'd1);
    if (byte_q.size() > b0) chk("t3_csum_zero", {56'd0, byte_q[b0]}, 64'h00);
`else
    wait_done(4, cyc, ok);
    tick();
    chk("t3_done_seen", {63'd0, ok}, 64'd1);
    chk("t3_done_within_2", {63'd0, (cyc <= 2)}, 64'd1);
    chk("t3_no_tx_edge", 64'(fall_cnt - f0), 64'd0);
`endif
    chk("t3_no_read", 64'(re_cnt - r0), 64'd0);
    chk("t3_done_count", 64'(done_cnt - d0), 64'd1);
    repeat (2) tick();

    // 4: start re-pulsed mid-dump is ignored
    mem[3] = 32'hCAFEBABE;
    b0 = byte_q.size(); d0 = done_cnt; r0 = re_cnt;
    pulse_start(4'd3, 5'd1);
    repeat (50) tick();
    pulse_start(4'd0, 5'd2);
    wait_done(400, cyc, ok);
    repeat (200) tick();
    chk("t4_done_seen", {63'd0, ok}, 64'd1);
    chk("t4_nbytes", 64'(byte_q.size() - b0), 64'(4 + CS));
    for (int i = 0; i < 4; i++)
      if (b0 + i < byte_q.size()) chk($sformatf("t4_byte%0d", i), {56'd0, byte_q[b0+i]}, {56'd0, exp4[i]});
    chk("t4_reads", 64'(re_cnt - r0), 64'd1);
    chk("t4_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t4_idle", {63'd0, busy}, 64'd0);

    // 5: reset during the second byte
    mem[0] = 32'h11223344;
    b0 = byte_q.size(); d0 = done_cnt;
    pulse_start(4'd0, 5'd1);
    cyc = 0;
    while (byte_q.size() == b0 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t5_first_byte_seen", {63'd0, (byte_q.size() > b0)}, 64'd1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("t5_tx_high", {63'd0, tx}, 64'd1);
    chk("t5_busy_low", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    repeat (100) tick();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_tx_idle", {63'd0, tx}, 64'd1);
    b0 = byte_q.size(); d0 = done_cnt;
    pulse_start(4'd15, 5'd1);
    wait_done(400, cyc, ok);
    tick();
    chk("t5_restart_done", {63'd0, ok}, 64'd1);
    chk("t5_restart_nbytes", 64'(byte_q.size() - b0), 64'(4 + CS));
    if (byte_q.size() > b0 + 3) begin
      chk("t5_restart_b0", {56'd0, byte_q[b0]}, 64'hDD);
      chk("t5_restart_b3", {56'd0, byte_q[b0+3]}, 64'hAA);
    end

    // 6: checksum case
    mem[0] = 32'h01020304;
    b0 = byte_q.size(); d0 = done_cnt;
    pulse_start(4'd0, 5'd1);
    wait_done(400, cyc, ok);
    tick();
    chk("t6_done_seen", {63'd0, ok}, 64'd1);
    chk("t6_nbytes", 64'(byte_q.size() - b0), 64'(4 + CS));
    for (int i = 0; i < 4; i++)
      if (b0 + i < byte_q.size()) chk($sformatf("t6_byte%0d", i), {56'd0, byte_q[b0+i]}, {56'd0, exp6[i]});
`ifdef DUMP_CHECKSUM_EN
    if (byte_q.size() > b0 + 4) chk("t6_csum", {56'd0, byte_q[b0+4]}, 64'h0A);
`endif
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
